cam_alloc_ctrl: RTL
===================

Name: cam_alloc_ctrl

Overview:
- Lookup-or-insert controller in front of one single-write-port, single-read-port CAM instance with DATA = KEY+1.
- Round-robin arbitrates REQ requesters. Each key is looked up; on a miss the key is allocated into the lowest free entry. Returns the entry index with a hit/new/full status.
- Keeps an entry-valid bitmap and accepts invalidations.
- CAM bit KEY is a valid tag: live entries hold {1,key}, so stale and reset cells never match.

Parameters:
- KEY, 15, key width; CAM data width is KEY+1.
- DEPTH, 64, CAM entries.
- REQ, 4, requester count.
- ADDR, $clog2(DEPTH), derived entry index width.
- RID, $clog2(REQ) (min 1), derived requester id width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  REQ  per-requester lookup request
- req_key  in  REQ x KEY  per-requester key
- req_ready  out  REQ  one-hot grant; request accepted when valid & ready
- inv_valid  in  1  invalidate request
- inv_addr  in  ADDR  entry to invalidate
- inv_ready  out  1  invalidate accepted when valid & ready
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  RID  requester index of response
- rsp_status  out  2  0=HIT, 1=NEW, 2=FULL
- rsp_addr  out  ADDR  entry index (0 on FULL)
- used_cnt  out  ADDR+1  number of valid entries
- cam_we_  out  1  CAM write enable, active-low
- cam_wm  out  KEY+1  CAM write mask (1 = bit not written)
- cam_wd  out  KEY+1  CAM write data
- cam_waddr  out  ADDR  CAM write address
- cam_re_  out  1  CAM read enable, active-low
- cam_rm  out  KEY+1  CAM read mask; always 0
- cam_rd  out  KEY+1  CAM search data
- cam_match  in  1  CAM match, combinational from CAM state
- cam_raddr  in  ADDR  CAM matched index

Behaviour:
- Reset values:
  - state=IDLE; valid bitmap=0; used_cnt=0.
  - rr pointer=REQ-1, so requester 0 has first priority.
  - rsp_valid=0, rsp_id=0, rsp_status=0, rsp_addr=0.
  - cam_we_=1, cam_re_=1.
  - Reset mid-operation aborts the operation; no response is issued.
- The CAM must itself be reset together with this block. Its zeroed cells have tag 0 and never match.
- FSM states: IDLE, LOOKUP, WRITE, RESP.
- IDLE:
  - req_ready is one-hot to the first valid requester after the rr pointer, and 0 if none.
  - On a grant: latch the key and id, update rr pointer to the granted id, go to LOOKUP.
  - inv_ready=1 only in IDLE.
- Invalidate (IDLE cycle):
  - Drive cam_we_=0, cam_waddr=inv_addr, cam_wm = all ones except bit KEY, cam_wd=0.
  - Clear the valid bit. Decrement used_cnt only if the bit was set; invalidating an invalid entry is a CAM write but no count change.
- Invalidate and grant in the same IDLE cycle are both accepted. The invalidate is visible to the following LOOKUP.
- LOOKUP:
  - Drive cam_re_=0, cam_rd={1,key}, cam_rm=0.
  - cam_match=1: rsp HIT, addr=cam_raddr, go to RESP.
  - Miss with free entry: latch alloc=lowest-index clear valid bit, go to WRITE.
  - Miss with used_cnt==DEPTH: rsp FULL, go to RESP.
- WRITE:
  - Drive cam_we_=0, cam_waddr=alloc, cam_wm=0, cam_wd={1,key}.
  - Set the valid bit, increment used_cnt, rsp NEW, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. Response outputs are registered and hold their value outside the pulse.
- Latency from acceptance edge to rsp_valid: HIT and FULL 2 cycles, NEW 3 cycles.
- Throughput is one request per 3 or 4 cycles. No new grant is issued outside IDLE.
- Only keys missing from the CAM are inserted, so at most one entry ever matches and cam_raddr is unambiguous.
- used_cnt saturates naturally at DEPTH and never wraps.
- The rr pointer wraps REQ-1 -> 0.
- cam_re_ and cam_we_ are 1 in every state and cycle not listed above.

Test Plan:
- After reset, req0 key 0x0000 -> LOOKUP miss, WRITE to entry 0; rsp NEW id0 addr0 3 cycles after accept; used_cnt=1.
- Repeat req0 key 0x0000 -> rsp HIT addr0 2 cycles after accept; used_cnt unchanged.
- Requesters 0-3 all valid continuously with distinct keys -> grant order 0,1,2,3,0; responses NEW at addr 0..3.
- Fill all 64 entries, then a new key 0x7FFF -> rsp FULL addr0. Invalidate entry 5 with a concurrent grant for key 0x7FFF -> NEW addr5, used_cnt back to 64.
- Invalidate entry 2 (key K2), then look up K2 -> miss, NEW at lowest free entry (2). Invalidate an already-invalid entry -> used_cnt unchanged.
- Assert reset during WRITE -> no rsp_valid, used_cnt=0, rsp outputs 0, next lookup of the same key returns NEW addr0.

Source files
------------

// File: rtl/cam_alloc_ctrl.sv
// rtl/cam_alloc_ctrl.sv - round-robin lookup-or-insert controller for a single-port CAM
module cam_alloc_ctrl #(
  parameter int KEY   = 15,
  parameter int DEPTH = 64,
  parameter int REQ   = 4,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int RID   = (REQ > 1) ? $clog2(REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REQ-1:0]           req_valid,
  input  logic [REQ-1:0][KEY-1:0]  req_key,
  output logic [REQ-1:0]           req_ready,
  input  logic                     inv_valid,
  input  logic [ADDR-1:0]          inv_addr,
  output logic                     inv_ready,
  output logic                     rsp_valid,
  output logic [RID-1:0]           rsp_id,
  output logic [1:0]               rsp_status,
  output logic [ADDR-1:0]          rsp_addr,
  output logic [ADDR:0]            used_cnt,
  output logic                     cam_we_,
  output logic [KEY:0]             cam_wm,
  output logic [KEY:0]             cam_wd,
  output logic [ADDR-1:0]          cam_waddr,
  output logic                     cam_re_,
  output logic [KEY:0]             cam_rm,
  output logic [KEY:0]             cam_rd,
  input  logic                     cam_match,
  input  logic [ADDR-1:0]          cam_raddr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0]    ST_HIT   = 2'd0;
  localparam logic [1:0]    ST_NEW   = 2'd1;
  localparam logic [1:0]    ST_FULL  = 2'd2;
  localparam logic [ADDR:0] CNT_ONE  = (ADDR+1)'(1);
  localparam logic [ADDR:0] CNT_FULL = (ADDR+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR:0]     used_q;
  logic [RID-1:0]    rr_q;
  logic [KEY-1:0]    key_q;
  logic [RID-1:0]    id_q;
  logic [ADDR-1:0]   alloc_q;
  logic [1:0]        pend_status_q;
  logic [ADDR-1:0]   pend_addr_q;

  logic [REQ-1:0]    grant_vec;
  logic [RID-1:0]    grant_id;
  logic              grant_any;
  logic [ADDR-1:0]   free_idx;
  logic              full;
  int                idx;

  assign used_cnt = used_q;
  assign full     = (used_q == CNT_FULL);
  assign cam_rm   = '0;

  // Round-robin pick: first valid requester after the last granted one
  always_comb begin
    grant_vec = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int i = 1; i <= REQ; i++) begin
      idx = (int'(rr_q) + i) % REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = RID'(idx);
      end
    end
    if (grant_any) grant_vec[grant_id] = 1'b1;
  end

  // Lowest-index free entry, used as the allocation target on a miss
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = ADDR'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the handshake and CAM port drive for the current state
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    inv_ready = 1'b0;
    cam_we_   = 1'b1;
    cam_wm    = '1;
    cam_wd    = '0;
    cam_waddr = '0;
    cam_re_   = 1'b1;
    cam_rd    = '0;
    case (state_q)
      S_IDLE: begin
        inv_ready = 1'b1;
        req_ready = grant_vec;
        if (inv_valid) begin
          // Only the tag bit is cleared; the stale key bits can no longer match
          cam_we_   = 1'b0;
          cam_waddr = inv_addr;
          cam_wm    = {1'b0, {KEY{1'b1}}};
          cam_wd    = '0;
        end
        if (grant_any) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        cam_re_ = 1'b0;
        cam_rd  = {1'b1, key_q};
        if (cam_match || full) state_d = S_RESP;
        else                   state_d = S_WRITE;
      end
      S_WRITE: begin
        cam_we_   = 1'b0;
        cam_waddr = alloc_q;
        cam_wm    = '0;
        cam_wd    = {1'b1, key_q};
        state_d   = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: request latch, valid bitmap, occupancy count and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      used_q        <= '0;
      rr_q          <= RID'(REQ-1);
      key_q         <= '0;
      id_q          <= '0;
      alloc_q       <= '0;
      pend_status_q <= ST_HIT;
      pend_addr_q   <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_status    <= ST_HIT;
      rsp_addr      <= '0;
    end else begin
      rsp_valid <= (state_q == S_RESP);
      case (state_q)
        S_IDLE: begin
          if (inv_valid) begin
            valid_q[inv_addr] <= 1'b0;
            if (valid_q[inv_addr]) used_q <= used_q - CNT_ONE;
          end
          if (grant_any) begin
            key_q <= req_key[grant_id];
            id_q  <= grant_id;
            rr_q  <= grant_id;
          end
        end
        S_LOOKUP: begin
          if (cam_match) begin
            pend_status_q <= ST_HIT;
            pend_addr_q   <= cam_raddr;
          end else if (full) begin
            pend_status_q <= ST_FULL;
            pend_addr_q   <= '0;
          end else begin
            alloc_q <= free_idx;
          end
        end
        S_WRITE: begin
          valid_q[alloc_q] <= 1'b1;
          used_q           <= used_q + CNT_ONE;
          pend_status_q    <= ST_NEW;
          pend_addr_q      <= alloc_q;
        end
        S_RESP: begin
          rsp_id     <= id_q;
          rsp_status <= pend_status_q;
          rsp_addr   <= pend_addr_q;
        end
        default: ;
      endcase
    end
  end

endmodule
